// File: rtl/cursor_ctrl_if.sv
// cursor_ctrl_if: raw buttons toward the cursor controller; select pulse and cursor position back.
interface cursor_ctrl_if;
  logic btnU, btnD, btnL, btnR, btnC, center;
  logic [6:0] cursorCor;
  logic [3:0] cursorRow, cursorCol;
  modport master (
    output btnU, btnD, btnL, btnR, btnC,
    input  center, cursorCor, cursorRow, cursorCol
  );
  modport slave (
    input  btnU, btnD, btnL, btnR, btnC,
    output center, cursorCor, cursorRow, cursorCol
  );
endinterface

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: five synchronised, debounced buttons drive a cursor on a GRID_SIZE x GRID_SIZE board.
// Define CURSOR_WRAP_EN to wrap at board edges; otherwise moves past an edge saturate.
module cursor_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int GRID_SIZE = 10
) (
  input logic clk,
  input logic reset,
  cursor_ctrl_if.slave io
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] POS_MAX = 4'(GRID_SIZE - 1);
  logic [4:0] raw, s1_q, s2_q, stable_q, stable_d, evt_q, evt_d;
  logic [4:0][CW-1:0] cnt_q, cnt_d;
  logic up, dn, lf, rt, cen, center_q;
  logic [3:0] row_q, row_d, col_q, col_d, row_dec, row_inc, col_dec, col_inc;
  logic [6:0] cor_q, cor_d;
  assign raw = {io.btnC, io.btnR, io.btnL, io.btnD, io.btnU};
  assign {cen, rt, lf, dn, up} = evt_q;
  // hit marks the edge on which the counter would reach DEBOUNCE_CYCLES
  for (genvar b = 0; b < 5; b++) begin : g_db
    logic hit;
    assign hit = (s2_q[b] != stable_q[b]) && (cnt_q[b] == CNT_LAST);
    assign cnt_d[b] = (s2_q[b] == stable_q[b] || hit) ? '0 : cnt_q[b] + 1'b1;
    assign stable_d[b] = stable_q[b] ^ hit;
    assign evt_d[b] = hit & ~stable_q[b];
  end
`ifdef CURSOR_WRAP_EN
  assign row_dec = (row_q == '0) ? POS_MAX : row_q - 4'd1;
  assign row_inc = (row_q == POS_MAX) ? '0 : row_q + 4'd1;
  assign col_dec = (col_q == '0) ? POS_MAX : col_q - 4'd1;
  assign col_inc = (col_q == POS_MAX) ? '0 : col_q + 4'd1;
`else
  assign row_dec = (row_q == '0) ? row_q : row_q - 4'd1;
  assign row_inc = (row_q == POS_MAX) ? row_q : row_q + 4'd1;
  assign col_dec = (col_q == '0) ? col_q : col_q - 4'd1;
  assign col_inc = (col_q == POS_MAX) ? col_q : col_q + 4'd1;
`endif
  assign row_d = (up && !dn) ? row_dec : (dn && !up) ? row_inc : row_q;
  assign col_d = (lf && !rt) ? col_dec : (rt && !lf) ? col_inc : col_q;
  assign cor_d = 7'(row_d) * 7'(GRID_SIZE) + 7'(col_d);
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      evt_q    <= '0;
      center_q <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      cor_q    <= '0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
      center_q <= cen;
      row_q    <= row_d;
      col_q    <= col_d;
      cor_q    <= cor_d;
    end
  end
  assign io.center    = center_q;
  assign io.cursorRow = row_q;
  assign io.cursorCol = col_q;
  assign io.cursorCor = cor_q;
endmodule

// File: tb/tb_cursor_ctrl.sv
// tb_cursor_ctrl: directed scenarios plus random button traffic against a sliding-window model.
module tb_cursor_ctrl;
  localparam int D = 4;
  localparam int G = 10;
`ifdef CURSOR_WRAP_EN
  localparam int EDGE_ROW = G - 1;
`else
  localparam int EDGE_ROW = 0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  cursor_ctrl_if io ();
  cursor_ctrl #(.DEBOUNCE_CYCLES(D), .GRID_SIZE(G)) dut (.clk(clk), .reset(reset), .io(io));
  always #5 clk = ~clk;
  bit hist[5][$];
  bit mstab[5];
  bit mevt[5];
  bit mcen;
  int mrow, mcol;
  function automatic int move(int v, int dlt);
`ifdef CURSOR_WRAP_EN
    return (v + dlt + G) % G;
`else
    return (v + dlt < 0 || v + dlt >= G) ? v : v + dlt;
`endif
  endfunction
  // An event fires once the last D synchronised samples (2 edges late) all disagree with the stable level.
  task automatic model_step();
    bit raw[5];
    raw = '{io.btnU, io.btnD, io.btnL, io.btnR, io.btnC};
    if (reset) begin
      for (int b = 0; b < 5; b++) begin
        hist[b].delete();
        repeat (D + 2) hist[b].push_back(1'b0);
        mstab[b] = 1'b0;
        mevt[b] = 1'b0;
      end
      mcen = 1'b0;
      mrow = 0;
      mcol = 0;
    end else begin
      mcen = mevt[4];
      if (mevt[0] && !mevt[1]) mrow = move(mrow, -1);
      if (mevt[1] && !mevt[0]) mrow = move(mrow, 1);
      if (mevt[2] && !mevt[3]) mcol = move(mcol, -1);
      if (mevt[3] && !mevt[2]) mcol = move(mcol, 1);
      for (int b = 0; b < 5; b++) begin
        bit all = 1'b1;
        int n;
        hist[b].push_back(raw[b]);
        if (hist[b].size() > D + 3) void'(hist[b].pop_front());
        n = hist[b].size();
        for (int j = n - 2 - D; j <= n - 3; j++) if (hist[b][j] == mstab[b]) all = 1'b0;
        mevt[b] = 1'b0;
        if (all) begin
          mstab[b] = ~mstab[b];
          mevt[b] = mstab[b];
        end
      end
    end
  endtask
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask
  task automatic drive(logic [4:0] m);
    {io.btnC, io.btnR, io.btnL, io.btnD, io.btnU} = m;
  endtask
  task automatic press(logic [4:0] m, int hold = 10, int rel = 10);
    drive(m);
    tick(hold);
    drive('0);
    tick(rel);
  endtask
  task automatic do_reset();
    drive('0);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask
  task automatic test_reset();
    drive(5'b11111);
    reset = 1'b1;
    tick(3);
    checks++;
    if (io.center !== 1'b0) begin errors++; $display("FAIL reset_center got %b want 0", io.center); end
    checks++;
    if (io.cursorRow !== 4'd0) begin errors++; $display("FAIL reset_row got %0d want 0", io.cursorRow); end
    checks++;
    if (io.cursorCol !== 4'd0) begin errors++; $display("FAIL reset_col got %0d want 0", io.cursorCol); end
    checks++;
    if (io.cursorCor !== 7'd0) begin errors++; $display("FAIL reset_cor got %0d want 0", io.cursorCor); end
    drive('0);
    tick();
    reset = 1'b0;
    tick(10);
  endtask
  task automatic test_center_hold();
    do_reset();
    drive(5'b10000);
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (io.center !== (k == D + 3)) begin
        errors++;
        $display("FAIL center_hold edge %0d got %b want %b", k, io.center, k == D + 3);
      end
      checks++;
      if (io.cursorCor !== 7'd0) begin errors++; $display("FAIL center_hold_cor edge %0d got %0d want 0", k, io.cursorCor); end
    end
    drive('0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (io.center !== 1'b0) begin errors++; $display("FAIL center_release edge %0d got %b want 0", k, io.center); end
    end
  endtask
  task automatic test_glitch();
    do_reset();
    drive(5'b01000);
    tick(D - 1);
    drive('0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if ({io.center, io.cursorCol, io.cursorCor} !== 12'd0) begin
        errors++;
        $display("FAIL glitch edge %0d got center=%b col=%0d cor=%0d want 0/0/0", k, io.center, io.cursorCol, io.cursorCor);
      end
    end
  endtask
  task automatic test_moves();
    do_reset();
    repeat (3) press(5'b01000);
    repeat (2) press(5'b00010);
    checks++;
    if ({io.cursorRow, io.cursorCol, io.cursorCor} !== {4'd2, 4'd3, 7'd23}) begin
      errors++;
      $display("FAIL moves got row=%0d col=%0d cor=%0d want 2/3/23", io.cursorRow, io.cursorCol, io.cursorCor);
    end
  endtask
  task automatic test_edge();
    do_reset();
    press(5'b00001);
    checks++;
    if ({io.cursorRow, io.cursorCol, io.cursorCor} !== {4'(EDGE_ROW), 4'd0, 7'(EDGE_ROW * G)}) begin
      errors++;
      $display("FAIL edge_up got row=%0d col=%0d cor=%0d want %0d/0/%0d", io.cursorRow, io.cursorCol, io.cursorCor, EDGE_ROW, EDGE_ROW * G);
    end
  endtask
  task automatic test_simultaneous();
    do_reset();
    repeat (5) press(5'b00010);
    checks++;
    if (io.cursorRow !== 4'd5) begin errors++; $display("FAIL sim_setup_row got %0d want 5", io.cursorRow); end
    press(5'b00011);
    checks++;
    if ({io.cursorRow, io.cursorCor} !== {4'd5, 7'd50}) begin
      errors++;
      $display("FAIL sim_updown got row=%0d cor=%0d want 5/50", io.cursorRow, io.cursorCor);
    end
    repeat (5) press(5'b01000);
    press(5'b00101);
    checks++;
    if ({io.cursorRow, io.cursorCol, io.cursorCor} !== {4'd4, 4'd4, 7'd44}) begin
      errors++;
      $display("FAIL sim_diag got row=%0d col=%0d cor=%0d want 4/4/44", io.cursorRow, io.cursorCol, io.cursorCor);
    end
  endtask
  task automatic test_reset_mid();
    int pulses = 0;
    int at = -1;
    do_reset();
    drive(5'b10000);
    for (int k = 1; k <= D; k++) begin
      tick();
      if (io.center) pulses++;
    end
    reset = 1'b1;
    tick();
    if (io.center) pulses++;
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (io.center) begin
        pulses++;
        if (at < 0) at = k;
      end
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL reset_mid_pulses got %0d want 1", pulses); end
    checks++;
    if (at !== D + 3) begin errors++; $display("FAIL reset_mid_edge got %0d want %0d", at, D + 3); end
    drive('0);
    tick(10);
  endtask
  task automatic test_random();
    logic [4:0] m = '0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 7) == 0) m[b] = ~m[b];
      drive(m);
      reset = ($urandom_range(0, 249) == 0);
      tick();
      checks++;
      if ({io.center, io.cursorRow, io.cursorCol, io.cursorCor} !== {mcen, 4'(mrow), 4'(mcol), 7'(mrow * G + mcol)}) begin
        errors++;
        $display("FAIL random cycle %0d got c=%b r=%0d c=%0d cor=%0d want c=%b r=%0d c=%0d cor=%0d", i,
                 io.center, io.cursorRow, io.cursorCol, io.cursorCor, mcen, mrow, mcol, mrow * G + mcol);
      end
    end
    reset = 1'b0;
    drive('0);
    tick(10);
  endtask
  initial begin
    drive('0);
    test_reset();
    test_center_hold();
    test_glitch();
    test_moves();
    test_edge();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
